mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 36 +++
 rtl/arb_select.sv | 29 ++
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status encoding, arbiter FSM states
// and the kind of access a grant refers to.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_IFETCH = 2'd0,
        SRC_DREAD  = 2'd1,
        SRC_DWRITE = 2'd2
    } src_t;

    localparam int NUM_CORES = 2;
    localparam int ADDR_W    = 32;

    // Within one core data beats instruction, and a read+write pair is a write.
    function automatic src_t core_src(input logic dren, input logic dwen);
        src_t s;
        if (dwen)      s = SRC_DWRITE;
        else if (dren) s = SRC_DREAD;
        else           s = SRC_IFETCH;
        return s;
    endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational source selector: picks one pending core and the access kind.
// Built with ARB_ROUND_ROBIN_EN the caller feeds a rotating priority core.
module arb_select
    import cpu_types_pkg::*;
(
    input  logic [NUM_CORES-1:0] iren,
    input  logic [NUM_CORES-1:0] dren,
    input  logic [NUM_CORES-1:0] dwen,
    input  logic                 prio_core,
    output logic                 gnt_valid,
    output logic                 gnt_core,
    output src_t                 gnt_src
);

    logic [NUM_CORES-1:0] pend;

    always_comb begin
        pend      = iren | dren | dwen;
        gnt_valid = |pend;
        gnt_core  = 1'b0;
        if (pend == 2'b11) begin
            gnt_core = prio_core;
        end else if (pend[1]) begin
            gnt_core = 1'b1;
        end
        gnt_src = core_src(dren[gnt_core], dwen[gnt_core]);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-core memory arbiter: IDLE grants one source, BUSY runs the RAM access,
// DONE gives the requester one cycle to move on. Option: ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         CLK,
    input  logic                         Rst,
    input  logic [NUM_CORES-1:0]         iREN,
    input  logic [NUM_CORES-1:0]         dREN,
    input  logic [NUM_CORES-1:0]         dWEN,
    input  logic [NUM_CORES-1:0][31:0]   iaddr,
    input  logic [NUM_CORES-1:0][31:0]   daddr,
    input  logic [NUM_CORES-1:0][31:0]   dstore,
    output logic [NUM_CORES-1:0]         iwait,
    output logic [NUM_CORES-1:0]         dwait,
    output logic [31:0]                  load,
    output logic                         ramREN,
    output logic                         ramWEN,
    output logic [ADDR_W-1:0]            ramaddr,
    output logic [31:0]                  ramstore,
    input  logic [31:0]                  ramload,
    input  logic [1:0]                   ramstate,
    output logic                         err,
    output arb_state_t                   dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_t       state_q, state_d;
    logic             gcore_q, gcore_d;
    src_t             gsrc_q, gsrc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic      prio_core;
    logic      sel_valid;
    logic      sel_core;
    src_t      sel_src;
    logic      gnt_active;
    ramstate_t ram_st;

    assign ram_st = ramstate_t'(ramstate);

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == ST_DONE) begin
            rr_ptr_d = ~gcore_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (Rst) rr_ptr_q <= 1'b0;
        else     rr_ptr_q <= rr_ptr_d;
    end

    assign prio_core = rr_ptr_q;
`else
    assign prio_core = 1'b0;
`endif

    arb_select u_sel (
        .iren      (iREN),
        .dren      (dREN),
        .dwen      (dWEN),
        .prio_core (prio_core),
        .gnt_valid (sel_valid),
        .gnt_core  (sel_core),
        .gnt_src   (sel_src)
    );

    always_comb begin
        case (gsrc_q)
            SRC_DWRITE: gnt_active = dWEN[gcore_q];
            SRC_DREAD:  gnt_active = dREN[gcore_q];
            default:    gnt_active = iREN[gcore_q];
        endcase
    end

    // Handshake: a request bit is held high until its wait bit goes low for one
    // cycle (the completing cycle); wait mirrors request at every other time.
    always_comb begin
        state_d  = state_q;
        gcore_d  = gcore_q;
        gsrc_d   = gsrc_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = dREN | dWEN;

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    gcore_d = sel_core;
                    gsrc_d  = sel_src;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!gnt_active) begin
                    state_d = ST_IDLE;
                end else begin
                    case (gsrc_q)
                        SRC_DWRITE: begin
                            ramWEN   = 1'b1;
                            ramaddr  = daddr[gcore_q];
                            ramstore = dstore[gcore_q];
                        end
                        SRC_DREAD: begin
                            ramREN  = 1'b1;
                            ramaddr = daddr[gcore_q];
                        end
                        default: begin
                            ramREN  = 1'b1;
                            ramaddr = iaddr[gcore_q];
                        end
                    endcase
                    if (ram_st == RAM_ACCESS) begin
                        if (gsrc_q == SRC_IFETCH) iwait[gcore_q] = 1'b0;
                        else                      dwait[gcore_q] = 1'b0;
                        state_d = ST_DONE;
                    end else if (ram_st == RAM_ERROR || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset is synchronous, so the registered state may still be BUSY here.
        if (Rst) begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = '0;
            ramstore = '0;
            iwait    = iREN;
            dwait    = dREN | dWEN;
        end
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            gcore_q <= 1'b0;
            gsrc_q  <= SRC_IFETCH;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gcore_q <= gcore_d;
            gsrc_q  <= gsrc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign err       = err_q;
    assign load      = ramload;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus a hand-written
// fetch sequence with variable RAM latency. Honours ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [31:0] A_I0 = 32'h0000_0040;
    localparam logic [31:0] A_I1 = 32'h0000_0080;
    localparam logic [31:0] A_D0 = 32'h0000_0100;
    localparam logic [31:0] A_D1 = 32'h0000_0200;
    localparam logic [31:0] S_0  = 32'hDEAD_BEEF;
    localparam logic [31:0] S_1  = 32'h1234_5678;

    logic             CLK;
    logic             Rst;
    logic [1:0]       iREN, dREN, dWEN;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait;
    logic [31:0]      load;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;
    logic             err;
    arb_state_t       dbg_state;

    typedef struct {
        logic        rst;
        logic [1:0]  ir, dr, dw;
        logic [1:0]  rs;
        logic [1:0]  st;
        logic [1:0]  iw, dwt;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic        er;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          total;
    int          bad;

    mem_arbiter #(.TIMEOUT_CYC(4)) dut (
        .CLK       (CLK),
        .Rst       (Rst),
        .iREN      (iREN),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .iaddr     (iaddr),
        .daddr     (daddr),
        .dstore    (dstore),
        .iwait     (iwait),
        .dwait     (dwait),
        .load      (load),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r, input logic [1:0] ir, input logic [1:0] dr,
                                input logic [1:0] dw, input logic [1:0] rs, input logic [1:0] st,
                                input logic [1:0] iw, input logic [1:0] dwt, input logic ren,
                                input logic wen, input logic [31:0] addr, input logic [31:0] store,
                                input logic er);
        vec_t v;
        v.rst = r;  v.ir = ir;   v.dr = dr;   v.dw = dw;   v.rs = rs;
        v.st  = st; v.iw = iw;   v.dwt = dwt; v.ren = ren; v.wen = wen;
        v.addr = addr; v.store = store; v.er = er;
        return v;
    endfunction

    task automatic chk(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", what, idx, act, exp);
        end
    endtask

    // driver: apply one vector just after the edge, compare on the falling edge
    task automatic run_vec(input int idx, input vec_t v);
        @(posedge CLK); #1;
        Rst      = v.rst;
        iREN     = v.ir;
        dREN     = v.dr;
        dWEN     = v.dw;
        ramstate = v.rs;
        ramload  = $urandom;
        @(negedge CLK);
        chk("state",    idx, 32'(dbg_state), 32'(v.st));
        chk("iwait",    idx, 32'(iwait),     32'(v.iw));
        chk("dwait",    idx, 32'(dwait),     32'(v.dwt));
        chk("ramREN",   idx, 32'(ramREN),    32'(v.ren));
        chk("ramWEN",   idx, 32'(ramWEN),    32'(v.wen));
        chk("ramaddr",  idx, ramaddr,        v.addr);
        chk("ramstore", idx, ramstore,       v.store);
        chk("err",      idx, 32'(err),       32'(v.er));
        chk("load",     idx, load,           ramload);
    endtask

    // core 1 fetch; RAM reports BUSY for dly cycles of BUSY state, then ACCESS
    task automatic fetch_seq(input logic [31:0] a, input int dly);
        int lat;
        lat = 0;
        @(posedge CLK); #1;
        iaddr[1] = a;
        iREN     = 2'b10;
        dREN     = 2'b00;
        dWEN     = 2'b00;
        ramstate = RAM_FREE;
        exp_q.push_back(a);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge CLK); #1;
            ramstate = (k > dly) ? RAM_ACCESS : RAM_BUSY;
            @(negedge CLK);
            if (iwait[1] == 1'b0) begin
                lat = k;
                chk("seq_latency", dly, lat, dly + 1);
                chk("seq_addr",    dly, ramaddr, exp_q.pop_front());
                chk("seq_ren",     dly, 32'(ramREN), 32'd1);
            end
        end
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL seq_timeout dly=%0d got=no completion want=completion", dly);
            void'(exp_q.pop_front());
        end
        @(posedge CLK); #1;
        iREN     = 2'b00;
        ramstate = RAM_FREE;
        @(negedge CLK);
        chk("seq_done", dly, 32'(dbg_state), 32'(ST_DONE));
        @(posedge CLK); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Rst = 1'b1;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr[0] = A_I0;  iaddr[1] = A_I1;
        daddr[0] = A_D0;  daddr[1] = A_D1;
        dstore[0] = S_0;  dstore[1] = S_1;
        ramload = '0;
        ramstate = RAM_FREE;
        @(posedge CLK);

        // r  ir     dr     dw     rs          st       iw     dw     ren   wen   addr   store  err
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, RAM_FREE,   ST_IDLE, 2'b01, 2'b00, 0, 0, 0,    0,   0));
        // single fetch, ACCESS on first BUSY cycle
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, RAM_FREE,   ST_IDLE, 2'b01, 2'b00, 0, 0, 0,    0,   0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, RAM_ACCESS, ST_BUSY, 2'b00, 2'b00, 1, 0, A_I0, 0,   0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, RAM_FREE,   ST_DONE, 2'b00, 2'b00, 0, 0, 0,    0,   0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, RAM_FREE,   ST_IDLE, 2'b00, 2'b00, 0, 0, 0,    0,   0));
        // write beats fetch on core 0
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b01, RAM_FREE,   ST_IDLE, 2'b01, 2'b01, 0, 0, 0,    0,   0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b01, RAM_ACCESS, ST_BUSY, 2'b01, 2'b00, 0, 1, A_D0, S_0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, RAM_FREE,   ST_DONE, 2'b01, 2'b00, 0, 0, 0,    0,   0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, RAM_FREE,   ST_IDLE, 2'b01, 2'b00, 0, 0, 0,    0,   0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, RAM_ACCESS, ST_BUSY, 2'b00, 2'b00, 1, 0, A_I0, 0,   0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, RAM_FREE,   ST_DONE, 2'b00, 2'b00, 0, 0, 0,    0,   0));
        // reset in the middle of a transaction
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, RAM_FREE,   ST_IDLE, 2'b11, 2'b00, 0, 0, 0,    0,   0));
        vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, RAM_ACCESS, ST_BUSY, 2'b11, 2'b00, 0, 0, 0,    0,   0));
        // both cores fetching continuously
        for (int n = 0; n < 4; n++) begin
            logic c1;
            c1 = RR && (n % 2 == 1);
            vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, RAM_FREE, ST_IDLE, 2'b11, 2'b00, 0, 0, 0, 0, 0));
            vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, RAM_ACCESS, ST_BUSY, c1 ? 2'b01 : 2'b10, 2'b00,
                              1, 0, c1 ? A_I1 : A_I0, 0, 0));
            vecs.push_back(mk(0, (n == 3) ? 2'b00 : 2'b11, 2'b00, 2'b00, RAM_FREE, ST_DONE,
                              (n == 3) ? 2'b00 : 2'b11, 2'b00, 0, 0, 0, 0, 0));
        end
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, RAM_FREE,   ST_IDLE, 2'b00, 2'b00, 0, 0, 0,    0,   0));
        // timeout after 4 BUSY cycles, then retry with a cleared counter
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, RAM_FREE,   ST_IDLE, 2'b00, 2'b10, 0, 0, 0,    0,   0));
        for (int n = 0; n < 4; n++)
            vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, RAM_BUSY, ST_BUSY, 2'b00, 2'b10, 1, 0, A_D1, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, RAM_FREE,   ST_IDLE, 2'b00, 2'b10, 0, 0, 0,    0,   1));
        for (int n = 0; n < 2; n++)
            vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, RAM_BUSY, ST_BUSY, 2'b00, 2'b10, 1, 0, A_D1, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, RAM_ACCESS, ST_BUSY, 2'b00, 2'b00, 1, 0, A_D1, 0,   0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, RAM_FREE,   ST_DONE, 2'b00, 2'b00, 0, 0, 0,    0,   0));
        // ERROR, then retry completes
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, RAM_FREE,   ST_IDLE, 2'b10, 2'b00, 0, 0, 0,    0,   0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, RAM_ERROR,  ST_BUSY, 2'b10, 2'b00, 1, 0, A_I1, 0,   0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, RAM_FREE,   ST_IDLE, 2'b10, 2'b00, 0, 0, 0,    0,   1));
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, RAM_ACCESS, ST_BUSY, 2'b00, 2'b00, 1, 0, A_I1, 0,   0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, RAM_FREE,   ST_DONE, 2'b00, 2'b00, 0, 0, 0,    0,   0));
        // request withdrawn during BUSY: silent abort
        vecs.push_back(mk(0, 2'b00, 2'b01, 2'b00, RAM_FREE,   ST_IDLE, 2'b00, 2'b01, 0, 0, 0,    0,   0));
        vecs.push_back(mk(0, 2'b00, 2'b01, 2'b00, RAM_BUSY,   ST_BUSY, 2'b00, 2'b01, 1, 0, A_D0, 0,   0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, RAM_BUSY,   ST_BUSY, 2'b00, 2'b00, 0, 0, 0,    0,   0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, RAM_FREE,   ST_IDLE, 2'b00, 2'b00, 0, 0, 0,    0,   0));
        // dREN+dWEN together on core 1 is a write
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b10, RAM_FREE,   ST_IDLE, 2'b00, 2'b10, 0, 0, 0,    0,   0));
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b10, RAM_ACCESS, ST_BUSY, 2'b00, 2'b00, 0, 1, A_D1, S_1, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, RAM_FREE,   ST_DONE, 2'b00, 2'b00, 0, 0, 0,    0,   0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, RAM_FREE,   ST_IDLE, 2'b00, 2'b00, 0, 0, 0,    0,   0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        fetch_seq(32'h0000_1000, 0);
        fetch_seq(32'h0000_2004, 1);
        fetch_seq(32'h0000_3008, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
